// File: rtl/activation_unit_pipe_pkg.sv
// ---------------------------------------------------------------------------
// act_pkg
// Shared types and constants for the activation pipeline.
//   act_mode_e   : activation selector carried alongside every beat
//   SIG_DEPTH    : number of sigmoid table entries (index range 0..99)
//   SIG_OFFSET   : bias added to the pre-scaled input to form a table index
//   SIG_FULL     : full-scale 8-bit output value
//   sigmoid_lut  : table lookup, entry i = floor(255 / (1 + exp(-(i-50)/10)))
// ---------------------------------------------------------------------------
package act_pkg;

  typedef enum logic [1:0] {
    SIGMOID = 2'd0,
    RELU    = 2'd1,
    STEP    = 2'd2,
    ZERO    = 2'd3
  } act_mode_e;

  localparam int SIG_DEPTH  = 100;
  localparam int SIG_OFFSET = 50;
  localparam int SIG_FULL   = 255;

  // The lower half mirrors the upper half: entry 50-k equals 254 - entry 50+k,
  // because 255*s(t) is never an integer for t != 0.
  localparam logic [7:0] SIG_LUT [SIG_DEPTH] = '{
      8'd1,   8'd1,   8'd2,   8'd2,   8'd2,   8'd2,   8'd3,   8'd3,   8'd3,   8'd4,
      8'd4,   8'd5,   8'd5,   8'd6,   8'd6,   8'd7,   8'd8,   8'd9,   8'd9,   8'd10,
      8'd12,  8'd13,  8'd14,  8'd16,  8'd17,  8'd19,  8'd21,  8'd23,  8'd25,  8'd27,
      8'd30,  8'd33,  8'd36,  8'd39,  8'd42,  8'd46,  8'd50,  8'd54,  8'd59,  8'd63,
      8'd68,  8'd73,  8'd79,  8'd84,  8'd90,  8'd96,  8'd102, 8'd108, 8'd114, 8'd121,
      8'd127, 8'd133, 8'd140, 8'd146, 8'd152, 8'd158, 8'd164, 8'd170, 8'd175, 8'd181,
      8'd186, 8'd191, 8'd195, 8'd200, 8'd204, 8'd208, 8'd212, 8'd215, 8'd218, 8'd221,
      8'd224, 8'd227, 8'd229, 8'd231, 8'd233, 8'd235, 8'd237, 8'd238, 8'd240, 8'd241,
      8'd242, 8'd244, 8'd245, 8'd245, 8'd246, 8'd247, 8'd248, 8'd248, 8'd249, 8'd249,
      8'd250, 8'd250, 8'd251, 8'd251, 8'd251, 8'd252, 8'd252, 8'd252, 8'd252, 8'd253
  };

  // Indices past the table end (never produced by the clamp) map to the last entry.
  function automatic logic [7:0] sigmoid_lut(input logic [6:0] idx);
    logic [7:0] value;
    if (idx > 7'd99) begin
      value = SIG_LUT[SIG_DEPTH-1];
    end else begin
      value = SIG_LUT[idx];
    end
    return value;
  endfunction

endpackage

// File: rtl/activation_unit_pipe_if.sv
// ---------------------------------------------------------------------------
// activation_unit_pipe_if
// Bundles the input beat, output beat and status of the activation pipeline.
//   in_valid/in_ready   : input handshake
//   in_mode             : activation selector for the beat (act_mode_e encoding)
//   in_x                : N_CH signed lanes, lane k at [k*IN_W +: IN_W]
//   out_valid/out_ready : output handshake
//   out_f               : N_CH unsigned lanes, lane k at [k*OUT_W +: OUT_W]
//   out_mode            : mode of the beat on out_f
//   sat_cnt             : saturating count of clamp events
// master = producer/consumer side, slave = the activation unit.
// ---------------------------------------------------------------------------
interface activation_unit_pipe_if #(
  parameter int N_CH  = 4,
  parameter int IN_W  = 32,
  parameter int OUT_W = 8,
  parameter int CNT_W = 16
);

  logic                    in_valid;
  logic                    in_ready;
  logic [1:0]              in_mode;
  logic [N_CH*IN_W-1:0]    in_x;
  logic                    out_valid;
  logic                    out_ready;
  logic [N_CH*OUT_W-1:0]   out_f;
  logic [1:0]              out_mode;
  logic [CNT_W-1:0]        sat_cnt;

  modport master (
    output in_valid, in_mode, in_x, out_ready,
    input  in_ready, out_valid, out_f, out_mode, sat_cnt
  );

  modport slave (
    input  in_valid, in_mode, in_x, out_ready,
    output in_ready, out_valid, out_f, out_mode, sat_cnt
  );

endinterface

// File: rtl/activation_unit_pipe_lane.sv
// ---------------------------------------------------------------------------
// act_lane
// Purely combinational per-lane compute, split around the S1 register.
// Front half (before S1):
//   i_x, i_mode        : raw signed lane input and its mode
//   o_pre              : clamped table index (sigmoid) or final value (others)
//   o_clampEvent       : lane was out of range and got clamped
// Back half (after S1):
//   i_pre, i_preMode   : registered o_pre and mode from S1
//   o_result           : lane output value, registered by S2
// ---------------------------------------------------------------------------
module act_lane
  import act_pkg::*;
#(
  parameter int IN_W  = 32,
  parameter int OUT_W = 8
) (
  input  logic signed [IN_W-1:0] i_x,
  input  act_mode_e              i_mode,
  output logic [OUT_W-1:0]       o_pre,
  output logic                   o_clampEvent,
  input  logic [OUT_W-1:0]       i_pre,
  input  act_mode_e              i_preMode,
  output logic [OUT_W-1:0]       o_result
);

  localparam logic signed [IN_W:0]   IDX_MIN    = '0;
  localparam logic signed [IN_W:0]   IDX_MAX    = (IN_W+1)'(SIG_DEPTH - 1);
  localparam logic signed [IN_W-1:0] RELU_MAX   = IN_W'((2**OUT_W) - 1);
  localparam logic [OUT_W-1:0]       FULL_SCALE = OUT_W'(SIG_FULL);

  // One extra bit so adding the offset can never overflow the lane width.
  logic signed [IN_W:0] w_idx;

  assign w_idx = $signed({i_x[IN_W-1], i_x}) + $signed((IN_W+1)'(SIG_OFFSET));

  // Front half: clamp the input into the range each mode can represent and
  // flag the lanes that needed it. Negative ReLU inputs are a normal zero,
  // not a clamp, so only the upper bound raises the flag there.
  always_comb begin
    o_pre        = '0;
    o_clampEvent = 1'b0;
    case (i_mode)
      SIGMOID: begin
        if (w_idx < IDX_MIN) begin
          o_pre        = '0;
          o_clampEvent = 1'b1;
        end else if (w_idx > IDX_MAX) begin
          o_pre        = OUT_W'(SIG_DEPTH - 1);
          o_clampEvent = 1'b1;
        end else begin
          o_pre = OUT_W'(w_idx[6:0]);
        end
      end
      RELU: begin
        if (i_x[IN_W-1]) begin
          o_pre = '0;
        end else if (i_x > RELU_MAX) begin
          o_pre        = '1;
          o_clampEvent = 1'b1;
        end else begin
          o_pre = i_x[OUT_W-1:0];
        end
      end
      STEP: begin
        o_pre = i_x[IN_W-1] ? '0 : FULL_SCALE;
      end
      default: begin
        o_pre = '0;
      end
    endcase
  end

  // Back half: only sigmoid still needs the table; every other mode already
  // carries its final value through S1.
  always_comb begin
    o_result = i_pre;
    if (i_preMode == SIGMOID) begin
      o_result = OUT_W'(sigmoid_lut(i_pre[6:0]));
    end
  end

endmodule

// File: rtl/activation_unit_pipe.sv
// ---------------------------------------------------------------------------
// activation_unit_pipe
// Two-stage, N_CH-lane activation stage with valid/ready flow control.
//   clk : rising-edge clock
//   rst : synchronous active-high reset, discards any in-flight beats
//   bus : activation_unit_pipe_if slave (input beat, output beat, sat_cnt)
// S1 holds per-lane clamped data plus mode; S2 holds the final lane values.
// in_ready depends combinationally only on out_ready and the stage valids.
// ---------------------------------------------------------------------------
module activation_unit_pipe
  import act_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int IN_W  = 32,
  parameter int OUT_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  activation_unit_pipe_if.slave bus
);

  localparam int SUM_W = CNT_W + $clog2(N_CH + 1);
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

  logic                  r_stage1Valid;
  logic                  r_stage2Valid;
  act_mode_e             r_stage1Mode;
  act_mode_e             r_outMode;
  logic [N_CH*OUT_W-1:0] r_stage1Pre;
  logic [N_CH*OUT_W-1:0] r_outF;
  logic [CNT_W-1:0]      r_satCnt;

  logic                  w_en1;
  logic                  w_en2;
  logic                  w_inXfer;
  act_mode_e             w_inMode;
  logic [N_CH*OUT_W-1:0] w_pre;
  logic [N_CH*OUT_W-1:0] w_result;
  logic [N_CH-1:0]       w_clampEvent;
  logic [SUM_W-1:0]      w_eventCount;
  logic [SUM_W-1:0]      w_cntSum;

  // A stage may load when it is empty or when the stage after it is moving,
  // so a full pipeline still shifts on a cycle where the output is taken.
  assign w_en2    = ~r_stage2Valid | bus.out_ready;
  assign w_en1    = ~r_stage1Valid | w_en2;
  assign w_inXfer = bus.in_valid & w_en1;
  assign w_inMode = act_mode_e'(bus.in_mode);

  genvar k;
  generate
    for (k = 0; k < N_CH; k++) begin : g_lane
      act_lane #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
      ) u_lane (
        .i_x          (bus.in_x[k*IN_W +: IN_W]),
        .i_mode       (w_inMode),
        .o_pre        (w_pre[k*OUT_W +: OUT_W]),
        .o_clampEvent (w_clampEvent[k]),
        .i_pre        (r_stage1Pre[k*OUT_W +: OUT_W]),
        .i_preMode    (r_stage1Mode),
        .o_result     (w_result[k*OUT_W +: OUT_W])
      );
    end
  endgenerate

  // Popcount of the incoming beat's clamp flags, added to the counter in a
  // wider word so the saturation test can see the overflow.
  always_comb begin
    w_eventCount = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_eventCount = w_eventCount + SUM_W'(w_clampEvent[i]);
    end
    w_cntSum = SUM_W'(r_satCnt) + w_eventCount;
  end

  // Pipeline registers. Data only loads alongside a valid so that a stalled
  // S2 beat keeps out_f/out_mode steady until it is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stage1Valid <= 1'b0;
      r_stage2Valid <= 1'b0;
      r_stage1Mode  <= SIGMOID;
      r_outMode     <= SIGMOID;
      r_stage1Pre   <= '0;
      r_outF        <= '0;
    end else begin
      if (w_en1) begin
        r_stage1Valid <= bus.in_valid;
        if (bus.in_valid) begin
          r_stage1Pre  <= w_pre;
          r_stage1Mode <= w_inMode;
        end
      end
      if (w_en2) begin
        r_stage2Valid <= r_stage1Valid;
        if (r_stage1Valid) begin
          r_outF    <= w_result;
          r_outMode <= r_stage1Mode;
        end
      end
    end
  end

  // Clamp events are counted when the beat is accepted, so the count never
  // depends on how long the beat later waits at the output.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_satCnt <= '0;
    end else if (w_inXfer) begin
      if (w_cntSum > CNT_MAX) begin
        r_satCnt <= '1;
      end else begin
        r_satCnt <= w_cntSum[CNT_W-1:0];
      end
    end
  end

  assign bus.in_ready  = w_en1;
  assign bus.out_valid = r_stage2Valid;
  assign bus.out_f     = r_outF;
  assign bus.out_mode  = r_outMode;
  assign bus.sat_cnt   = r_satCnt;

endmodule

// File: tb/tb_activation_unit_pipe.sv
// ---------------------------------------------------------------------------
// tb_activation_unit_pipe
// Self-checking bench for activation_unit_pipe. A queue of expected beats is
// built from the activation rules (real-valued sigmoid, plain comparisons)
// and compared against the DUT every cycle. A second instance with a 4-bit
// counter exercises counter saturation.
// ---------------------------------------------------------------------------
module tb_activation_unit_pipe;

  localparam int N_CH      = 4;
  localparam int IN_W      = 32;
  localparam int OUT_W     = 8;
  localparam int CNT_W     = 16;
  localparam int SAT_CNT_W = 4;
  localparam longint CNT_TOP  = (64'd1 << CNT_W) - 1;
  localparam longint SAT4_TOP = (64'd1 << SAT_CNT_W) - 1;

  typedef struct {
    logic [N_CH*OUT_W-1:0] f;
    logic [1:0]            mode;
    int                    acceptEdge;
  } beat_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  beat_t  expQ[$];
  int     checks    = 0;
  int     failures  = 0;
  int     edgeCount = 0;
  longint expSat    = 0;
  longint expSat4   = 0;
  logic   lastInXfer = 1'b0;

  logic       curValid    = 1'b0;
  logic [1:0] curMode     = 2'd0;
  int         curX [N_CH];
  logic       curOutReady = 1'b1;

  activation_unit_pipe_if #(.N_CH(N_CH), .IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) bus ();
  activation_unit_pipe_if #(.N_CH(N_CH), .IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(SAT_CNT_W)) satBus ();

  activation_unit_pipe #(.N_CH(N_CH), .IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .clk (clock),
    .rst (reset),
    .bus (bus)
  );

  activation_unit_pipe #(.N_CH(N_CH), .IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(SAT_CNT_W)) satDut (
    .clk (clock),
    .rst (reset),
    .bus (satBus)
  );

  // Free-running clock, period 10.
  always #5 clock = ~clock;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Reference behaviour of one lane, straight from the activation rules.
  function automatic void refLane(input int x, input logic [1:0] mode, output int f, output int ev);
    longint idx;
    f  = 0;
    ev = 0;
    case (mode)
      2'd0: begin
        idx = longint'(x) + 50;
        if (idx < 0) begin
          idx = 0;
          ev  = 1;
        end else if (idx > 99) begin
          idx = 99;
          ev  = 1;
        end
        f = int'($floor(255.0 / (1.0 + $exp(-(real'(idx) - 50.0) / 10.0))));
      end
      2'd1: begin
        if (x > 255) begin
          f  = 255;
          ev = 1;
        end else if (x < 0) begin
          f = 0;
        end else begin
          f = x;
        end
      end
      2'd2: f = (x >= 0) ? 255 : 0;
      default: f = 0;
    endcase
  endfunction

  function automatic int randX();
    int v;
    case ($urandom_range(0, 3))
      0:       v = int'($urandom_range(0, 160)) - 80;
      1:       v = int'($urandom_range(0, 340)) - 20;
      2:       v = int'($urandom);
      default: v = int'($urandom_range(0, 10)) - 5;
    endcase
    return v;
  endfunction

  task automatic applyStimulus(input logic valid, input logic [1:0] mode,
                               input int x0, input int x1, input int x2, input int x3,
                               input logic outReady);
    logic [N_CH*IN_W-1:0] packedX;
    curValid    = valid;
    curMode     = mode;
    curX[0]     = x0;
    curX[1]     = x1;
    curX[2]     = x2;
    curX[3]     = x3;
    curOutReady = outReady;
    for (int k = 0; k < N_CH; k++) begin
      packedX[k*IN_W +: IN_W] = curX[k];
    end
    bus.in_valid  = valid;
    bus.in_mode   = mode;
    bus.in_x      = packedX;
    bus.out_ready = outReady;
  endtask

  // One clock of the main DUT: check outputs mid-cycle, advance the model
  // with the handshakes the rules say happen at the coming edge.
  task automatic runCycle();
    logic                  expValid;
    logic                  expReady;
    logic                  inXfer;
    logic                  outXfer;
    int                    f;
    int                    ev;
    int                    pop;
    beat_t                 b;
    @(negedge clock);
    expValid = 1'b0;
    if (expQ.size() > 0) begin
      expValid = (edgeCount - expQ[0].acceptEdge) >= 1;
    end
    expReady = !((expQ.size() >= 2) && !curOutReady);
    checkOutput("out_valid", {63'd0, bus.out_valid}, {63'd0, expValid});
    checkOutput("in_ready", {63'd0, bus.in_ready}, {63'd0, expReady});
    checkOutput("sat_cnt", 64'(bus.sat_cnt), expSat);
    if (expValid) begin
      checkOutput("out_f", 64'(bus.out_f), 64'(expQ[0].f));
      checkOutput("out_mode", 64'(bus.out_mode), 64'(expQ[0].mode));
    end
    inXfer  = !reset && curValid && expReady;
    outXfer = !reset && expValid && curOutReady;
    if (outXfer) begin
      void'(expQ.pop_front());
    end
    pop = 0;
    if (inXfer) begin
      b.f = '0;
      for (int k = 0; k < N_CH; k++) begin
        refLane(curX[k], curMode, f, ev);
        b.f[k*OUT_W +: OUT_W] = OUT_W'(f);
        pop += ev;
      end
      b.mode       = curMode;
      b.acceptEdge = edgeCount + 1;
      expQ.push_back(b);
    end
    lastInXfer = inXfer;
    @(posedge clock);
    edgeCount++;
    if (reset) begin
      expQ.delete();
      expSat = 0;
    end else if (inXfer) begin
      expSat = (expSat + pop > CNT_TOP) ? CNT_TOP : expSat + pop;
    end
    #1;
  endtask

  // Single directed beat with no stalls, checked against fixed constants two
  // edges after acceptance.
  task automatic directedBeat(input string tag, input logic [1:0] mode,
                              input int x0, input int x1, input int x2, input int x3,
                              input logic [31:0] wantF, input longint wantSat);
    applyStimulus(1'b1, mode, x0, x1, x2, x3, 1'b1);
    runCycle();
    applyStimulus(1'b0, 2'd0, 0, 0, 0, 0, 1'b1);
    runCycle();
    checkOutput({tag, "_valid"}, {63'd0, bus.out_valid}, 64'd1);
    checkOutput({tag, "_f"}, 64'(bus.out_f), 64'(wantF));
    checkOutput({tag, "_mode"}, 64'(bus.out_mode), 64'(mode));
    checkOutput({tag, "_sat"}, 64'(bus.sat_cnt), wantSat);
    runCycle();
  endtask

  initial begin
    applyStimulus(1'b0, 2'd0, 0, 0, 0, 0, 1'b1);
    satBus.in_valid  = 1'b0;
    satBus.in_mode   = 2'd0;
    satBus.in_x      = '0;
    satBus.out_ready = 1'b1;

    // Reset state
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    checkOutput("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    checkOutput("rst_out_f", 64'(bus.out_f), 64'd0);
    checkOutput("rst_out_mode", 64'(bus.out_mode), 64'd0);
    checkOutput("rst_sat_cnt", 64'(bus.sat_cnt), 64'd0);
    checkOutput("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    checkOutput("rst_sat4_cnt", 64'(satBus.sat_cnt), 64'd0);

    // Reset arriving while the second beat is being accepted
    applyStimulus(1'b1, 2'd0, 1000, 1000, 1000, 1000, 1'b1);
    runCycle();
    reset = 1'b1;
    applyStimulus(1'b1, 2'd1, 5, 6, 7, 8, 1'b1);
    runCycle();
    reset = 1'b0;
    checkOutput("midrst_valid", {63'd0, bus.out_valid}, 64'd0);
    checkOutput("midrst_sat", 64'(bus.sat_cnt), 64'd0);
    applyStimulus(1'b1, 2'd2, 3, -3, 0, 9, 1'b1);
    runCycle();
    applyStimulus(1'b0, 2'd0, 0, 0, 0, 0, 1'b1);
    repeat (4) runCycle();

    // Directed activation checks
    directedBeat("sig", 2'd0, -50, 0, 49, 200, 32'hFDFD7F01, 1);
    directedBeat("relu", 2'd1, -7, 0, 100, 300, 32'hFF640000, 2);
    directedBeat("step", 2'd2, -1, 0, 5, -300, 32'h00FFFF00, 2);
    directedBeat("zero", 2'd3, 123, -999, 100000, -5, 32'h00000000, 2);

    // Back-pressure: out_ready follows 1,0,0,1,...
    begin
      int sent;
      int cyc;
      sent = 0;
      cyc  = 0;
      while (sent < 10 && cyc < 300) begin
        applyStimulus(1'b1, 2'd1, 10 + sent*20, 11 + sent*20, 12 + sent*20, 13 + sent*20,
                      (cyc % 4 == 0) || (cyc % 4 == 3));
        runCycle();
        if (lastInXfer) sent++;
        cyc++;
      end
      applyStimulus(1'b0, 2'd0, 0, 0, 0, 0, 1'b1);
      repeat (4) runCycle();
    end

    // Randomized traffic with random stalls
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                    randX(), randX(), randX(), randX(), $urandom_range(0, 2) != 0);
      runCycle();
    end
    applyStimulus(1'b0, 2'd0, 0, 0, 0, 0, 1'b1);
    repeat (4) runCycle();

    // Counter saturation on the 4-bit instance
    for (int b = 0; b < 5; b++) begin
      satBus.in_valid  = 1'b1;
      satBus.in_mode   = 2'd0;
      satBus.in_x      = {N_CH{32'd1000}};
      satBus.out_ready = 1'b1;
      @(negedge clock);
      checkOutput("sat4_ready", {63'd0, satBus.in_ready}, 64'd1);
      @(posedge clock);
      #1;
      expSat4 = (expSat4 + N_CH > SAT4_TOP) ? SAT4_TOP : expSat4 + N_CH;
      checkOutput("sat4_cnt", 64'(satBus.sat_cnt), expSat4);
      if (b == 3) checkOutput("sat4_at4", 64'(satBus.sat_cnt), 64'd15);
    end
    satBus.in_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #1000000;
    failures++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/activation_unit_pipe.md
Name: activation_unit_pipe

Overview:
- Pipelined, multi-lane activation stage placed between the neuron accumulator and the next layer's input buffer.
- Applies a runtime-selectable activation to N_CH signed accumulator values per beat: sigmoid LUT, ReLU, step, or zero.
- Clamps out-of-range inputs instead of returning 0, and keeps a saturating count of clamp events.
- Uses a valid/ready handshake in and out, with full back-pressure.

Parameters:
- N_CH, 4, number of parallel lanes per beat.
- IN_W, 32, signed input width per lane. Inputs are pre-scaled by 10 (x = 10·z).
- OUT_W, 8, unsigned output width per lane. Must be ≥ 8. Full scale 255 is zero-extended.
- CNT_W, 16, width of the saturation-event counter.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  unit can accept a beat this cycle.
- in_mode  in  2  activation mode: 0 sigmoid, 1 ReLU, 2 step, 3 zero.
- in_x  in  N_CH*IN_W  signed lane inputs; lane k is bits [k*IN_W +: IN_W].
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_f  out  N_CH*OUT_W  lane results; lane k is bits [k*OUT_W +: OUT_W].
- out_mode  out  2  mode of the beat currently on out_f.
- sat_cnt  out  CNT_W  saturating count of clamp events.

Behaviour:
- Reset (rst=1 at a clock edge): out_valid=0, out_f=0, out_mode=0, sat_cnt=0, both stage valids cleared. in_ready=1 in the first cycle after reset. Reset wins over any simultaneous handshake, and an in-flight beat is discarded.
- Pipeline: S1 registers per-lane pre-processed data and mode. S2 registers the lookup/result onto out_f. Latency is 2 cycles from accepted input to out_valid with no stalls. Throughput is 1 beat/cycle.
- Enables:
  - en2 = !v2 | out_ready
  - en1 = !v1 | en2
  - in_ready = en1
- Transfers:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - out_f and out_mode hold stable while out_valid=1 and out_ready=0.
  - No combinational path from in_valid to out_valid. The only combinational path is out_ready to in_ready.
- Sigmoid (mode 0), per lane:
  - idx = x + 50, computed as a signed IN_W+1-bit value.
  - idx < 0 → idx = 0. idx > 99 → idx = 99.
  - Result is LUT[idx], with LUT[i] = floor(255/(1+exp(-(i-50)/10))) for i = 0..99. Anchor values: LUT[0]=1, LUT[50]=127, LUT[99]=253.
- ReLU (mode 1): x < 0 → 0. x > 2^OUT_W-1 → 2^OUT_W-1. Otherwise x.
- Step (mode 2): x ≥ 0 → 255, else 0.
- Zero (mode 3): all lanes output 0.
- Clamp event, per lane:
  - Sigmoid lane with idx outside 0..99.
  - ReLU lane with x > 2^OUT_W-1. A negative x under ReLU is not an event.
- sat_cnt update:
  - On each input transfer, add the popcount of the beat's clamp events.
  - Saturate at 2^CNT_W-1 and never wrap.
  - Counted at acceptance, so it is independent of output stalls.
- Simultaneous input and output transfer with both stages full: the pipeline shifts and no beat is lost or duplicated.

Decomposition:
- Package act_pkg holds:
  - act_mode_e enum (SIGMOID=0, RELU=1, STEP=2, ZERO=3).
  - Constants SIG_DEPTH=100, SIG_OFFSET=50, SIG_FULL=255.
  - Function sigmoid_lut(idx) returning the 100-entry table.
- One sub-module, act_lane, holds the per-lane combinational compute (clamp, lookup, event flag). It is instantiated N_CH times by generate.

Test Plan:
- Reset mid-stream: issue 3 beats, assert rst on the cycle the 2nd is accepted → the next cycle has out_valid=0 and sat_cnt=0, and no stale beat emerges afterwards.
- Sigmoid sweep, lanes x = {-50, 0, 49, 200}, mode 0, out_ready=1 → two cycles later out_f lanes = {1, 127, 253, 253}, sat_cnt=1.
- ReLU/step: mode 1 with x = {-7, 0, 100, 300} → {0, 0, 100, 255}, sat_cnt +1. Then mode 2 with x = {-1, 0, 5, -300} → {0, 255, 255, 0}, sat_cnt +0.
- Back-pressure: stream 10 beats with distinct values while out_ready toggles 1,0,0,1,… → outputs arrive in order with none dropped, in_ready=0 whenever both stages are full and out_ready=0, and out_f stays stable while stalled.
- Counter saturation: CNT_W=4, feed 5 beats of 4 sigmoid lanes at x=1000 → sat_cnt=15 after the 4th beat and stays 15.
- Mode 3 with arbitrary inputs → out_f=0 on all lanes, out_mode=3, sat_cnt unchanged.
